fifo_256_rd_stream: RTL

FIFO_256_RD_STREAM -- requirements
Module: fifo_256_rd_stream

---
 rtl/fifo_256_rd_stream.sv | 93 +++++++++
 1 files changed

// File: rtl/fifo_256_rd_stream.sv
// Drains a standard-mode 256-bit FIFO into a valid/ready stream with m_last every BURST_LEN beats.
// Optional: define FIFO_RD_CNT_EN to add the 32-bit rd_cnt beat counter port.
module fifo_256_rd_stream #(
  parameter int BURST_LEN = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fifo_rdy,
  input  logic         fifo_empty,
  output logic         fifo_rd_en,
  input  logic [255:0] fifo_dout,
  output logic [255:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [31:0]  rd_cnt
`endif
);

  typedef enum logic {
    WAIT_RDY,
    RUN
  } state_t;

  localparam logic [9:0] LAST_BEAT = 10'(BURST_LEN - 1);

  state_t       state;
  logic [1:0]   occ;
  logic         infl;
  logic [255:0] mem0;
  logic [255:0] mem1;
  logic [9:0]   beat;

  logic         pop;
  logic [1:0]   fill_after;
  logic [255:0] e0;
  logic [255:0] e1;

  // The arriving word counts as buffer content in the cycle it is presented, so an
  // empty buffer forwards fifo_dout directly; this gives the one-cycle first-word latency.
  always_comb begin
    m_valid    = ~rst & ((occ != 2'd0) | infl);
    m_data     = (occ != 2'd0) ? mem0 : fifo_dout;
    pop        = m_valid & m_ready;
    m_last     = m_valid & (beat == LAST_BEAT);
    fill_after = occ + {1'b0, infl} - {1'b0, pop};
    fifo_rd_en = ~rst & (state == RUN) & ~fifo_empty & (fill_after < 2'd2);
    e0 = mem0;
    e1 = mem1;
    case (occ)
      2'd0:    e0 = fifo_dout;
      2'd1:    e1 = fifo_dout;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_RDY;
      occ   <= '0;
      infl  <= 1'b0;
      beat  <= '0;
    end else begin
      if (state == WAIT_RDY && fifo_rdy) begin
        state <= RUN;
      end
      infl <= fifo_rd_en;
      occ  <= fill_after;
      if (pop) begin
        beat <= (beat == LAST_BEAT) ? '0 : beat + 10'd1;
      end
    end
  end

  // Ordered entries {e0, e1}; a pop drops e0. At most two remain after any cycle.
  always_ff @(posedge clk) begin
    mem0 <= pop ? e1 : e0;
    mem1 <= e1;
  end

`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
    end else if (pop) begin
      rd_cnt <= rd_cnt + 32'd1;
    end
  end
`endif

endmodule
